// File: rtl/character_position_file.sv
// -----------------------------------------------------------------------------
// character_position_file
//
// Pixel-coordinate store for Pacman (index 0) and NUM_CHARS-1 ghosts, with a
// sequential collision scanner.
//
// Ports
//   clock_50            system clock, all state changes on the rising edge
//   reset_n             asynchronous active-low reset (everyone goes home)
//   wr_en/wr_id/wr_x/wr_y  write port; illegal writes raise wr_err next cycle
//   wr_err              one-cycle pulse: previous cycle's write was rejected
//   rd_en/rd_id         read request, one-cycle latency
//   rd_valid            one-cycle pulse qualifying rd_x/rd_y/rd_err
//   rd_x/rd_y           read data, held while rd_valid is low
//   rd_err              read id was out of range (data forced to 0)
//   home_req            reload all home positions; aborts a running scan
//   scan_start          start a collision scan (only honoured in IDLE)
//   scan_busy           scanner in SCAN
//   scan_done           scanner in DONE (one cycle)
//   hit_mask            bit k set when ghost k shares Pacman's tile
//   collision           OR of hit_mask
// -----------------------------------------------------------------------------
module character_position_file #(
  parameter int NUM_CHARS  = 5,
  parameter int ID_W       = 3,
  parameter int COORD_W    = 8,
  parameter int X_MAX      = 159,
  parameter int Y_MAX      = 119,
  parameter int HOME_BASE  = 2,
  parameter int HOME_STEP  = 20,
  parameter int TILE_SHIFT = 2
) (
  input  logic                 clock_50,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [ID_W-1:0]      wr_id,
  input  logic [COORD_W-1:0]   wr_x,
  input  logic [COORD_W-1:0]   wr_y,
  output logic                 wr_err,
  input  logic                 rd_en,
  input  logic [ID_W-1:0]      rd_id,
  output logic                 rd_valid,
  output logic [COORD_W-1:0]   rd_x,
  output logic [COORD_W-1:0]   rd_y,
  output logic                 rd_err,
  input  logic                 home_req,
  input  logic                 scan_start,
  output logic                 scan_busy,
  output logic                 scan_done,
  output logic [NUM_CHARS-1:0] hit_mask,
  output logic                 collision
);

  localparam logic [ID_W:0]      NUM_CHARS_C = (ID_W+1)'(NUM_CHARS);
  localparam logic [ID_W-1:0]    LAST_IDX    = ID_W'(NUM_CHARS - 1);
  localparam logic [ID_W-1:0]    FIRST_GHOST = ID_W'(1);
  localparam logic [COORD_W-1:0] X_MAX_C     = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_MAX_C     = COORD_W'(Y_MAX);

  // Home coordinate of character k (x and y are identical). Ghost homes wrap
  // modulo 2^COORD_W.
  function automatic logic [COORD_W-1:0] home_of(input int k);
    int p;
    p = (k == 0) ? HOME_BASE : k * HOME_STEP;
    return p[COORD_W-1:0];
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } scan_state_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] x_reg [NUM_CHARS];
  logic [COORD_W-1:0] y_reg [NUM_CHARS];

  logic wr_in_range;
  logic wr_legal;
  logic wr_accept;
  logic wr_reject;
  logic rd_in_range;

  assign wr_in_range = ({1'b0, wr_id} < NUM_CHARS_C);
  assign rd_in_range = ({1'b0, rd_id} < NUM_CHARS_C);
  assign wr_legal    = wr_in_range && (wr_x <= X_MAX_C) && (wr_y <= Y_MAX_C);
  // A home request swallows a same-edge write silently.
  assign wr_accept   = wr_en && !home_req && wr_legal;
  assign wr_reject   = wr_en && !home_req && !wr_legal;

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CHARS; k++) begin
        x_reg[k] <= home_of(k);
        y_reg[k] <= home_of(k);
      end
    end else if (home_req) begin
      for (int k = 0; k < NUM_CHARS; k++) begin
        x_reg[k] <= home_of(k);
        y_reg[k] <= home_of(k);
      end
    end else if (wr_accept) begin
      x_reg[wr_id] <= wr_x;
      y_reg[wr_id] <= wr_y;
    end
  end

  // ---------------------------------------------------------------------------
  // Write error and read port
  // ---------------------------------------------------------------------------
  logic               wr_err_reg;
  logic               rd_valid_reg;
  logic               rd_err_reg;
  logic [COORD_W-1:0] rd_x_reg;
  logic [COORD_W-1:0] rd_y_reg;

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_err_reg   <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_err_reg   <= 1'b0;
      rd_x_reg     <= '0;
      rd_y_reg     <= '0;
    end else begin
      wr_err_reg   <= wr_reject;
      rd_valid_reg <= rd_en;
      rd_err_reg   <= rd_en && !rd_in_range;
      // Reads see the pre-edge contents, so a same-edge write is invisible.
      if (rd_en) begin
        if (rd_in_range) begin
          rd_x_reg <= x_reg[rd_id];
          rd_y_reg <= y_reg[rd_id];
        end else begin
          rd_x_reg <= '0;
          rd_y_reg <= '0;
        end
      end
    end
  end

  assign wr_err   = wr_err_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_err   = rd_err_reg;
  assign rd_x     = rd_x_reg;
  assign rd_y     = rd_y_reg;

  // ---------------------------------------------------------------------------
  // Collision scanner
  // ---------------------------------------------------------------------------
  scan_state_t          state_reg, state_next;
  logic [ID_W-1:0]      idx_reg, idx_next;
  logic [NUM_CHARS-1:0] hit_reg, hit_next;
  logic [COORD_W-1:0]   snap_x_reg, snap_x_next;
  logic [COORD_W-1:0]   snap_y_reg, snap_y_next;

  // Live tile match of every character against the Pacman snapshot; the
  // scanner picks out the ghost under idx. Entry 0 exists only so the vector
  // can be indexed directly by idx.
  logic [NUM_CHARS-1:0] tile_match;

  generate
    for (genvar gi = 0; gi < NUM_CHARS; gi++) begin : g_tile
      assign tile_match[gi] = ((x_reg[gi] >> TILE_SHIFT) == snap_x_reg) &&
                              ((y_reg[gi] >> TILE_SHIFT) == snap_y_reg);
    end
  endgenerate

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_IDLE;
      idx_reg    <= '0;
      hit_reg    <= '0;
      snap_x_reg <= '0;
      snap_y_reg <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      hit_reg    <= hit_next;
      snap_x_reg <= snap_x_next;
      snap_y_reg <= snap_y_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    hit_next    = hit_reg;
    snap_x_next = snap_x_reg;
    snap_y_next = snap_y_reg;

    case (state_reg)
      S_IDLE: begin
        if (scan_start && !home_req) begin
          state_next  = S_SCAN;
          idx_next    = FIRST_GHOST;
          hit_next    = '0;
          snap_x_next = x_reg[0] >> TILE_SHIFT;
          snap_y_next = y_reg[0] >> TILE_SHIFT;
        end
      end

      S_SCAN: begin
        if (home_req) begin
          // Abort: positions are being reloaded, so the partial result is void.
          state_next = S_IDLE;
          idx_next   = '0;
          hit_next   = '0;
        end else begin
          if (tile_match[idx_reg]) begin
            hit_next[idx_reg] = 1'b1;
          end
          if (idx_reg == LAST_IDX) begin
            state_next = S_DONE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign scan_busy = (state_reg == S_SCAN);
  assign scan_done = (state_reg == S_DONE);
  assign hit_mask  = hit_reg;
  assign collision = |hit_reg;

endmodule

// File: tb/tb_character_position_file.sv
// -----------------------------------------------------------------------------
// tb_character_position_file
//
// Scoreboard bench: the stimulus side updates a behavioural model of the
// character table and scanner and pushes expected read, write-error and
// scan results into queues; a monitor on the falling edge pops and compares
// whenever the DUT presents rd_valid, wr_err or scan_done.
// -----------------------------------------------------------------------------
module tb_character_position_file;

  localparam int N   = 5;
  localparam int IDW = 3;
  localparam int CW  = 8;
  localparam int XM  = 159;
  localparam int YM  = 119;
  localparam int HB  = 2;
  localparam int HS  = 20;
  localparam int TS  = 2;

  logic           clock_50 = 1'b0;
  logic           reset_n;
  logic           wr_en;
  logic [IDW-1:0] wr_id;
  logic [CW-1:0]  wr_x;
  logic [CW-1:0]  wr_y;
  logic           wr_err;
  logic           rd_en;
  logic [IDW-1:0] rd_id;
  logic           rd_valid;
  logic [CW-1:0]  rd_x;
  logic [CW-1:0]  rd_y;
  logic           rd_err;
  logic           home_req;
  logic           scan_start;
  logic           scan_busy;
  logic           scan_done;
  logic [N-1:0]   hit_mask;
  logic           collision;

  always #5 clock_50 = ~clock_50;

  character_position_file #(
    .NUM_CHARS (N),
    .ID_W      (IDW),
    .COORD_W   (CW),
    .X_MAX     (XM),
    .Y_MAX     (YM),
    .HOME_BASE (HB),
    .HOME_STEP (HS),
    .TILE_SHIFT(TS)
  ) dut (
    .clock_50  (clock_50),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_id     (wr_id),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_err    (wr_err),
    .rd_en     (rd_en),
    .rd_id     (rd_id),
    .rd_valid  (rd_valid),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_err    (rd_err),
    .home_req  (home_req),
    .scan_start(scan_start),
    .scan_busy (scan_busy),
    .scan_done (scan_done),
    .hit_mask  (hit_mask),
    .collision (collision)
  );

  typedef struct {
    int due;
    int x;
    int y;
    int err;
  } rd_exp_t;

  typedef struct {
    int due;
    int mask;
  } sc_exp_t;

  rd_exp_t rq[$];
  sc_exp_t sq[$];
  int      wq[$];

  // Behavioural model state
  int mx[N];
  int my[N];
  bit scan_active;
  bit in_done;
  int scan_k;
  int scan_mask;
  int snap_tx;
  int snap_ty;
  bit exp_busy;

  int edge_no = 0;
  int total   = 0;
  int bad     = 0;

  function automatic int home(input int k);
    return (k == 0) ? HB : ((k * HS) % (1 << CW));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic miss(input string name, input int due);
    total++;
    bad++;
    $display("FAIL %s: got no pulse, expected one after edge %0d", name, due);
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mx[k] = home(k);
      my[k] = home(k);
    end
    scan_active = 1'b0;
    in_done     = 1'b0;
    exp_busy    = 1'b0;
    rq.delete();
    sq.delete();
    wq.delete();
  endtask

  task automatic idle();
    wr_en      = 1'b0;
    wr_id      = '0;
    wr_x       = '0;
    wr_y       = '0;
    rd_en      = 1'b0;
    rd_id      = '0;
    home_req   = 1'b0;
    scan_start = 1'b0;
  endtask

  // Apply the currently driven inputs for one rising edge, advancing the model
  // from the pre-edge state.
  task automatic step();
    bit was_done;
    int wid;
    int rid;
    rid = int'(rd_id);
    wid = int'(wr_id);
    if (rd_en) begin
      if (rid < N) rq.push_back('{edge_no + 1, mx[rid], my[rid], 0});
      else         rq.push_back('{edge_no + 1, 0, 0, 1});
    end
    was_done = in_done;
    in_done  = 1'b0;
    if (scan_active) begin
      if (home_req) begin
        scan_active = 1'b0;
      end else begin
        if (((mx[scan_k] >> TS) == snap_tx) && ((my[scan_k] >> TS) == snap_ty))
          scan_mask = scan_mask | (1 << scan_k);
        if (scan_k == N - 1) begin
          sq.push_back('{edge_no + 1, scan_mask});
          scan_active = 1'b0;
          in_done     = 1'b1;
        end else begin
          scan_k++;
        end
      end
    end else if (!was_done && scan_start && !home_req) begin
      scan_active = 1'b1;
      scan_k      = 1;
      scan_mask   = 0;
      snap_tx     = mx[0] >> TS;
      snap_ty     = my[0] >> TS;
    end
    if (home_req) begin
      for (int k = 0; k < N; k++) begin
        mx[k] = home(k);
        my[k] = home(k);
      end
    end else if (wr_en) begin
      if (wid < N && int'(wr_x) <= XM && int'(wr_y) <= YM) begin
        mx[wid] = int'(wr_x);
        my[wid] = int'(wr_y);
      end else begin
        wq.push_back(edge_no + 1);
      end
    end
    @(posedge clock_50);
    edge_no++;
    exp_busy = scan_active;
    #1;
  endtask

  task automatic do_write(input int id, input int x, input int y);
    idle();
    wr_en = 1'b1;
    wr_id = IDW'(id);
    wr_x  = CW'(x);
    wr_y  = CW'(y);
    step();
    idle();
  endtask

  task automatic do_read(input int id);
    idle();
    rd_en = 1'b1;
    rd_id = IDW'(id);
    step();
    idle();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_err"},    int'(wr_err),    0);
    chk({tag, "_rd_valid"},  int'(rd_valid),  0);
    chk({tag, "_rd_x"},      int'(rd_x),      0);
    chk({tag, "_rd_y"},      int'(rd_y),      0);
    chk({tag, "_rd_err"},    int'(rd_err),    0);
    chk({tag, "_scan_busy"}, int'(scan_busy), 0);
    chk({tag, "_scan_done"}, int'(scan_done), 0);
    chk({tag, "_hit_mask"},  int'(hit_mask),  0);
    chk({tag, "_collision"}, int'(collision), 0);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin
    rd_exp_t re;
    sc_exp_t se;
    int      wd;
    forever begin
      @(negedge clock_50);
      if (reset_n === 1'b1) begin
        if (rd_valid) begin
          if (rq.size() == 0) begin
            chk("rd_unexpected", 1, 0);
          end else begin
            re = rq.pop_front();
            chk("rd_time", edge_no, re.due);
            chk("rd_x",    int'(rd_x),   re.x);
            chk("rd_y",    int'(rd_y),   re.y);
            chk("rd_err",  int'(rd_err), re.err);
            $display("read  edge=%0d x=%0d y=%0d err=%0d", edge_no, rd_x, rd_y, rd_err);
          end
        end
        while (rq.size() > 0 && rq[0].due <= edge_no) begin
          re = rq.pop_front();
          miss("rd_missing", re.due);
        end

        if (wr_err) begin
          if (wq.size() == 0) begin
            chk("wr_err_unexpected", 1, 0);
          end else begin
            wd = wq.pop_front();
            chk("wr_err_time", edge_no, wd);
            $display("wrerr edge=%0d", edge_no);
          end
        end
        while (wq.size() > 0 && wq[0] <= edge_no) begin
          wd = wq.pop_front();
          miss("wr_err_missing", wd);
        end

        if (scan_done) begin
          if (sq.size() == 0) begin
            chk("scan_done_unexpected", 1, 0);
          end else begin
            se = sq.pop_front();
            chk("scan_time", edge_no, se.due);
            chk("hit_mask",  int'(hit_mask),  se.mask);
            chk("collision", int'(collision), (se.mask != 0) ? 1 : 0);
            $display("scan  edge=%0d hit_mask=%b collision=%0d", edge_no, hit_mask, collision);
          end
        end
        while (sq.size() > 0 && sq[0].due <= edge_no) begin
          se = sq.pop_front();
          miss("scan_done_missing", se.due);
        end

        chk("scan_busy", int'(scan_busy), int'(exp_busy));
      end
    end
  end

  initial begin
    idle();
    reset_n = 1'b0;
    model_reset();
    #23;
    check_all_zero("reset");
    #4;
    reset_n = 1'b1;
    @(negedge clock_50);

    // Home positions after reset
    for (int i = 0; i < N; i++) do_read(i);
    step();

    // Write legality
    do_write(2, 100, 50);
    do_read(2);
    do_write(5, 1, 1);
    do_read(5);
    do_write(1, 160, 10);
    do_read(1);
    do_write(3, 20, 120);
    do_read(3);

    // Same-edge read and write of id 3: old value returned
    idle();
    rd_en = 1'b1; rd_id = 3'd3;
    wr_en = 1'b1; wr_id = 3'd3; wr_x = 8'd70; wr_y = 8'd71;
    step();
    do_read(3);

    // Home request beats a same-edge write, no wr_err
    idle();
    home_req = 1'b1;
    wr_en = 1'b1; wr_id = 3'd0; wr_x = 8'd9; wr_y = 8'd9;
    step();
    idle();
    do_read(0);
    do_read(3);

    // Collision scan with mid-scan Pacman write and ignored scan_start
    do_write(0, 41, 42);
    do_write(2, 40, 40);
    do_write(4, 43, 43);
    idle(); scan_start = 1'b1; step();
    do_write(0, 0, 0);
    idle(); scan_start = 1'b1; step();
    idle(); step();
    step();
    step();
    step();

    // Ghost 4 leaves the tile before it is compared
    do_write(0, 41, 42);
    idle(); scan_start = 1'b1; step();
    idle(); step();
    do_write(4, 100, 100);
    idle(); step(); step(); step(); step();

    // Home request aborts a running scan
    do_write(4, 43, 43);
    idle(); scan_start = 1'b1; step();
    idle(); step();
    idle(); home_req = 1'b1; step();
    idle();
    chk("abort_hit_mask",  int'(hit_mask),  0);
    chk("abort_collision", int'(collision), 0);
    chk("abort_busy",      int'(scan_busy), 0);
    for (int i = 0; i < 6; i++) step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      wr_en = ($urandom_range(0, 2) == 0);
      wr_id = IDW'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        wr_x = CW'($urandom_range(36, 50));
        wr_y = CW'($urandom_range(36, 50));
      end else begin
        wr_x = CW'($urandom_range(0, 200));
        wr_y = CW'($urandom_range(0, 140));
      end
      rd_en      = ($urandom_range(0, 1) == 0);
      rd_id      = IDW'($urandom_range(0, 7));
      scan_start = ($urandom_range(0, 5) == 0);
      home_req   = ($urandom_range(0, 39) == 0);
      step();
    end
    idle();
    for (int i = 0; i < 8; i++) step();

    // Asynchronous reset in the middle of a scan
    do_write(0, 41, 42);
    idle(); scan_start = 1'b1; step();
    idle(); rd_en = 1'b1; rd_id = 3'd0; step();
    idle();
    reset_n = 1'b0;
    #1;
    check_all_zero("midscan_reset");
    model_reset();
    @(negedge clock_50);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) do_read(i);
    for (int i = 0; i < 4; i++) step();

    chk("rd_queue_empty",   rq.size(), 0);
    chk("wr_queue_empty",   wq.size(), 0);
    chk("scan_queue_empty", sq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
